// File: rtl/hamming_secded_scrubber.sv
// -----------------------------------------------------------------------------
// hamming_secded_scrubber
//
// Background scrubber for a small memory protected by a (13,8) Hamming SECDED
// code. Each pass walks DEPTH entries. Every entry is read and classified:
//   - clean: nothing to do
//   - single error: fix it and write it back
//   - double error or invalid syndrome: count it and report it
// The host may write the same memory at any time. The scrubber defers to the
// host: it does not capture a read while a host write is in flight, and it
// does not write back over a host write.
//
// Codeword layout: code[12:1] hold Hamming positions 1..12. The parity bits
// are at positions 1, 2, 4 and 8. The data bits d0..d7 are at positions
// 3, 5, 6, 7, 9, 10, 11 and 12. code[0] is the even overall parity of
// code[12:1].
//
// Ports
//   clk              rising-edge clock
//   rst              asynchronous reset, active low
//   start            request one scrub pass (honoured only when idle)
//   host_wr_en       host write to the shared memory this cycle
//   host_addr        address of that host write
//   mem_addr         scrubber address into the memory (scan address)
//   mem_rdata        codeword at mem_addr (combinational read)
//   mem_wr_en        write-back strobe
//   mem_wdata        corrected codeword for write-back
//   busy             high whenever a pass is in progress
//   done             one-cycle pulse at the end of a pass
//   corr_count       corrected single errors (saturates at 255)
//   uncorr_count     uncorrectable words seen (saturates at 255)
//   uncorr_flag      sticky: set by any uncorrectable word
//   last_uncorr_addr address of the most recent uncorrectable word
// -----------------------------------------------------------------------------
module hamming_secded_scrubber #(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        host_wr_en,
  input  logic [3:0]  host_addr,
  output logic [3:0]  mem_addr,
  input  logic [12:0] mem_rdata,
  output logic        mem_wr_en,
  output logic [12:0] mem_wdata,
  output logic        busy,
  output logic        done,
  output logic [7:0]  corr_count,
  output logic [7:0]  uncorr_count,
  output logic        uncorr_flag,
  output logic [3:0]  last_uncorr_addr
);

  localparam logic [3:0] LAST_ADDR = 4'(DEPTH - 1);
  localparam logic [7:0] CNT_MAX   = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CHECK,
    WRITE,
    NEXT,
    DONE
  } state_t;

  state_t      state_reg;
  logic [3:0]  scan_addr_reg;
  logic [12:0] word_reg;
  logic [7:0]  corr_count_reg;
  logic [7:0]  uncorr_count_reg;
  logic        uncorr_flag_reg;
  logic [3:0]  last_uncorr_addr_reg;

  // Positions 1..12 covered by syndrome bit k: every position whose index
  // has bit k set.
  function automatic logic [11:0] cover_mask(input int k);
    logic [11:0] m;
    for (int p = 1; p <= 12; p++) begin
      m[p-1] = ((p >> k) & 1) != 0;
    end
    return m;
  endfunction

  logic [3:0]  syndrome;
  logic        parity_odd;
  logic        err_single;
  logic        err_uncorr;
  logic [12:0] flip_mask;
  logic        host_hit;

  for (genvar gi = 0; gi < 4; gi++) begin : g_syndrome
    assign syndrome[gi] = ^(word_reg[12:1] & cover_mask(gi));
  end

  assign parity_odd = ^word_reg;
  // Odd overall parity with syndrome 0 means code[0] itself flipped, so the
  // shift below lands on bit 0 in that case.
  assign err_single = parity_odd && (syndrome <= 4'd12);
  assign err_uncorr = (!parity_odd && (syndrome != 4'd0)) ||
                      (parity_odd && (syndrome > 4'd12));
  assign flip_mask  = 13'd1 << syndrome;
  // A host write to the entry being scrubbed makes the captured word stale.
  assign host_hit   = host_wr_en && (host_addr == scan_addr_reg);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg            <= IDLE;
      scan_addr_reg        <= 4'd0;
      word_reg             <= 13'd0;
      corr_count_reg       <= 8'd0;
      uncorr_count_reg     <= 8'd0;
      uncorr_flag_reg      <= 1'b0;
      last_uncorr_addr_reg <= 4'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            scan_addr_reg <= 4'd0;
            state_reg     <= READ;
          end
        end
        READ: begin
          // Any host write may be modifying the memory, so do not sample yet.
          if (!host_wr_en) begin
            word_reg  <= mem_rdata;
            state_reg <= CHECK;
          end
        end
        CHECK: begin
          if (err_single) begin
            word_reg <= word_reg ^ flip_mask;
            if (corr_count_reg != CNT_MAX) begin
              corr_count_reg <= corr_count_reg + 8'd1;
            end
            state_reg <= host_hit ? NEXT : WRITE;
          end else if (err_uncorr) begin
            if (uncorr_count_reg != CNT_MAX) begin
              uncorr_count_reg <= uncorr_count_reg + 8'd1;
            end
            uncorr_flag_reg      <= 1'b1;
            last_uncorr_addr_reg <= scan_addr_reg;
            state_reg            <= NEXT;
          end else begin
            state_reg <= NEXT;
          end
        end
        WRITE: begin
          // Leave once the write went out, or give up if the host overwrote
          // this entry. Stall while the host writes some other entry.
          if (!host_wr_en || host_hit) begin
            state_reg <= NEXT;
          end
        end
        NEXT: begin
          if (scan_addr_reg == LAST_ADDR) begin
            state_reg <= DONE;
          end else begin
            scan_addr_reg <= scan_addr_reg + 4'd1;
            state_reg     <= READ;
          end
        end
        DONE: begin
          scan_addr_reg <= 4'd0;
          state_reg     <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // The write strobe must also drop when the host takes the memory.
  // It follows the state register, so the asynchronous reset clears it at once.
  assign mem_wr_en        = (state_reg == WRITE) && !host_wr_en;
  assign mem_addr         = scan_addr_reg;
  assign mem_wdata        = word_reg;
  assign busy             = (state_reg != IDLE);
  assign done             = (state_reg == DONE);
  assign corr_count       = corr_count_reg;
  assign uncorr_count     = uncorr_count_reg;
  assign uncorr_flag      = uncorr_flag_reg;
  assign last_uncorr_addr = last_uncorr_addr_reg;

endmodule

// File: tb/tb_hamming_secded_scrubber.sv
// -----------------------------------------------------------------------------
// tb_hamming_secded_scrubber
//
// Bench for the SECDED scrubber. The shared memory lives in the bench. It
// takes host writes and scrubber write-backs, and it returns mem_rdata
// combinationally. A reference model walks each pass as plain sequential
// code and checks the DUT outputs on every falling edge. The model encodes
// data and decodes by searching for a single-bit flip that yields a valid
// codeword. Directed scenarios add literal expectations on top.
// -----------------------------------------------------------------------------
module tb_hamming_secded_scrubber;

  localparam int DEPTH = 16;
  localparam int DPOS [8] = '{3, 5, 6, 7, 9, 10, 11, 12};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        host_wr_en = 1'b0;
  logic [3:0]  host_addr = 4'd0;
  logic [12:0] host_wdata = 13'd0;
  logic [3:0]  mem_addr;
  logic [12:0] mem_rdata;
  logic        mem_wr_en;
  logic [12:0] mem_wdata;
  logic        busy;
  logic        done;
  logic [7:0]  corr_count;
  logic [7:0]  uncorr_count;
  logic        uncorr_flag;
  logic [3:0]  last_uncorr_addr;

  logic [12:0] mem [DEPTH];
  logic [12:0] img [DEPTH];
  logic        load_req = 1'b0;

  int cyc_cnt = 0;
  int n_checks = 0;
  int n_fail = 0;
  bit model_on = 1'b1;
  int m_corr = 0;
  int m_uncorr = 0;
  logic m_flag = 1'b0;
  logic [3:0] m_last = 4'd0;

  int done_cyc = 0;
  int wr_count = 0;
  int wr_cyc = 0;
  logic [3:0]  wr_last_addr = 4'd0;
  logic [12:0] wr_last_data = 13'd0;

  hamming_secded_scrubber #(.DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .host_wr_en       (host_wr_en),
    .host_addr        (host_addr),
    .mem_addr         (mem_addr),
    .mem_rdata        (mem_rdata),
    .mem_wr_en        (mem_wr_en),
    .mem_wdata        (mem_wdata),
    .busy             (busy),
    .done             (done),
    .corr_count       (corr_count),
    .uncorr_count     (uncorr_count),
    .uncorr_flag      (uncorr_flag),
    .last_uncorr_addr (last_uncorr_addr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Shared memory: image preload, host writes and scrubber write-backs.
  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= img[i];
    end else begin
      if (host_wr_en) mem[host_addr] <= host_wdata;
      if (mem_wr_en) mem[mem_addr] <= mem_wdata;
    end
  end

  assign mem_rdata = mem[mem_addr];

  // Transaction monitor for the directed scenarios.
  always @(negedge clk) begin
    if (done) done_cyc = cyc_cnt;
    if (mem_wr_en) begin
      wr_count++;
      wr_cyc = cyc_cnt;
      wr_last_addr = mem_addr;
      wr_last_data = mem_wdata;
      $display("write-back: cycle %0d addr %0d data 0x%04h", cyc_cnt, mem_addr, mem_wdata);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc_cnt, act, exp);
    end
  endtask

  // ---------------- reference code model ----------------
  function automatic logic [12:0] encode(input logic [7:0] d);
    logic [12:0] c;
    logic par;
    c = 13'd0;
    for (int i = 0; i < 8; i++) c[DPOS[i]] = d[i];
    for (int k = 0; k < 4; k++) begin
      par = 1'b0;
      for (int p = 1; p <= 12; p++) if (((p >> k) & 1) != 0) par ^= c[p];
      c[1 << k] = par;
    end
    c[0] = ^c[12:1];
    return c;
  endfunction

  function automatic logic [7:0] data_of(input logic [12:0] w);
    logic [7:0] d;
    for (int i = 0; i < 8; i++) d[i] = w[DPOS[i]];
    return d;
  endfunction

  function automatic bit is_valid(input logic [12:0] w);
    return w == encode(data_of(w));
  endfunction

  // cls: 0 clean, 1 correctable (fixed = repaired word), 2 uncorrectable
  function automatic void classify(input logic [12:0] w, output int cls, output logic [12:0] fixed);
    logic [12:0] t;
    cls = 2;
    fixed = w;
    if (is_valid(w)) cls = 0;
    else begin
      for (int b = 0; b < 13; b++) begin
        t = w ^ (13'd1 << b);
        if (is_valid(t)) begin
          cls = 1;
          fixed = t;
        end
      end
    end
  endfunction

  function automatic logic [12:0] rand_word();
    logic [12:0] w;
    int r, b1, b2;
    w = encode(8'($urandom));
    r = int'($urandom % 10);
    if (r >= 5 && r < 8) w ^= 13'd1 << ($urandom % 13);
    else if (r == 8) begin
      b1 = int'($urandom % 13);
      b2 = (b1 + 1 + int'($urandom % 12)) % 13;
      w ^= (13'd1 << b1) ^ (13'd1 << b2);
    end else if (r == 9) w = 13'($urandom);
    return w;
  endfunction

  task automatic expect_outputs(input logic e_busy, input logic e_done, input logic e_wr,
                                input logic [3:0] e_addr, input logic [12:0] e_wdata);
    chk("busy", busy, e_busy);
    chk("done", done, e_done);
    chk("mem_wr_en", mem_wr_en, e_wr);
    chk("mem_addr", mem_addr, e_addr);
    if (e_wr) chk("mem_wdata", mem_wdata, e_wdata);
    chk("corr_count", corr_count, m_corr[7:0]);
    chk("uncorr_count", uncorr_count, m_uncorr[7:0]);
    chk("uncorr_flag", uncorr_flag, m_flag);
    chk("last_uncorr_addr", last_uncorr_addr, m_last);
  endtask

  // One pass, one falling edge per DUT cycle.
  task automatic model_pass();
    logic [12:0] w, fixed;
    int cls;
    bit coll;
    w = 13'd0;
    for (int a = 0; a < DEPTH; a++) begin
      forever begin
        expect_outputs(1'b1, 1'b0, 1'b0, a[3:0], 13'd0);
        if (!host_wr_en) begin
          w = mem[a];
          break;
        end
        @(negedge clk);
      end
      @(negedge clk);
      expect_outputs(1'b1, 1'b0, 1'b0, a[3:0], 13'd0);
      classify(w, cls, fixed);
      coll = host_wr_en && (host_addr == a[3:0]);
      if (cls == 1 && m_corr < 255) m_corr++;
      if (cls == 2) begin
        if (m_uncorr < 255) m_uncorr++;
        m_flag = 1'b1;
        m_last = a[3:0];
      end
      @(negedge clk);
      if (cls == 1 && !coll) begin
        forever begin
          expect_outputs(1'b1, 1'b0, !host_wr_en, a[3:0], fixed);
          if (!host_wr_en || host_addr == a[3:0]) break;
          @(negedge clk);
        end
        @(negedge clk);
      end
      expect_outputs(1'b1, 1'b0, 1'b0, a[3:0], 13'd0);
      @(negedge clk);
    end
    expect_outputs(1'b1, 1'b1, 1'b0, 4'(DEPTH - 1), 13'd0);
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    forever begin
      if (!rst) begin
        m_corr = 0;
        m_uncorr = 0;
        m_flag = 1'b0;
        m_last = 4'd0;
        if (model_on) begin
          expect_outputs(1'b0, 1'b0, 1'b0, 4'd0, 13'd0);
          chk("reset mem_wdata", mem_wdata, 13'd0);
        end
        @(negedge clk);
      end else if (!model_on) begin
        @(negedge clk);
      end else begin
        expect_outputs(1'b0, 1'b0, 1'b0, 4'd0, 13'd0);
        if (start) begin
          @(negedge clk);
          model_pass();
        end else begin
          @(negedge clk);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic load_image();
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
  endtask

  task automatic clean_image();
    for (int i = 0; i < DEPTH; i++) img[i] = encode(8'(i));
  endtask

  // Runs one pass. The host writes to ha during cycles [hs, hs+hl) after the
  // start edge. Returns the done cycle and the last write-back cycle, both
  // relative to the start edge.
  task automatic run_pass(input int hs, input int hl, input logic [3:0] ha,
                          input logic [12:0] hd, output int done_rel, output int wr_rel);
    int s, n;
    bit got;
    wr_count = 0;
    wr_cyc = 0;
    done_cyc = 0;
    start = 1'b1;
    s = cyc_cnt;
    tick();
    start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      n = cyc_cnt - s;
      host_wr_en = (n >= hs) && (n < hs + hl);
      host_addr = ha;
      host_wdata = hd;
      tick();
      if (done_cyc != 0) got = 1'b1;
    end
    host_wr_en = 1'b0;
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL pass_timeout: got no done, expected done within 400 cycles");
    end
    done_rel = done_cyc - s;
    wr_rel = wr_cyc - s;
    $display("pass: done in cycle %0d, %0d write-backs, corr %0d uncorr %0d",
             done_rel, wr_count, corr_count, uncorr_count);
    tick();
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cls, dr, wrr;
    logic [12:0] fx, bad;

    #2 rst = 1'b0;
    repeat (3) tick();
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    chk("reset mem_wr_en", mem_wr_en, 1'b0);
    chk("reset mem_addr", mem_addr, 4'd0);
    chk("reset corr_count", corr_count, 8'd0);
    chk("reset uncorr_flag", uncorr_flag, 1'b0);

    // Hand-computed pins for the model.
    chk("model enc A5", encode(8'hA5), 13'h144E);
    chk("model enc 01", encode(8'h01), 13'h000F);
    classify(13'h144E ^ 13'h0080, cls, fx);
    chk("model single cls", cls, 1);
    chk("model single fix", fx, 13'h144E);
    classify(13'h144E ^ 13'h0408, cls, fx);
    chk("model double cls", cls, 2);
    rst = 1'b1;
    tick();

    // Clean memory.
    clean_image();
    load_image();
    run_pass(0, 0, 4'd0, 13'd0, dr, wrr);
    chk("clean done cycle", dr, 49);
    chk("clean writes", wr_count, 0);
    chk("clean corr", corr_count, 8'd0);
    chk("clean uncorr", uncorr_count, 8'd0);

    // Single error at entry 5 on code[7].
    do_reset();
    clean_image();
    img[5] = encode(8'hA5) ^ 13'h0080;
    load_image();
    run_pass(0, 0, 4'd0, 13'd0, dr, wrr);
    chk("single done cycle", dr, 50);
    chk("single writes", wr_count, 1);
    chk("single wr addr", wr_last_addr, 4'd5);
    chk("single wr data", wr_last_data, 13'h144E);
    chk("single corr", corr_count, 8'd1);
    chk("single mem5", mem[5], 13'h144E);
    run_pass(0, 0, 4'd0, 13'd0, dr, wrr);
    chk("persist corr", corr_count, 8'd1);
    chk("persist done", dr, 49);

    // Double error at entry 9 on code[3] and code[10].
    do_reset();
    clean_image();
    img[9] = encode(8'h09) ^ 13'h0408;
    load_image();
    run_pass(0, 0, 4'd0, 13'd0, dr, wrr);
    chk("double writes", wr_count, 0);
    chk("double uncorr", uncorr_count, 8'd1);
    chk("double flag", uncorr_flag, 1'b1);
    chk("double last addr", last_uncorr_addr, 4'd9);
    chk("double corr", corr_count, 8'd0);
    chk("double done", dr, 49);

    // Only the overall parity bit flipped at entry 2.
    do_reset();
    clean_image();
    img[2] = encode(8'h02) ^ 13'h0001;
    load_image();
    run_pass(0, 0, 4'd0, 13'd0, dr, wrr);
    chk("p0 writes", wr_count, 1);
    chk("p0 wr addr", wr_last_addr, 4'd2);
    chk("p0 wr data", wr_last_data, encode(8'h02));
    chk("p0 corr", corr_count, 8'd1);

    // The host overwrites entry 4 while it is in CHECK (cycle 14).
    do_reset();
    clean_image();
    img[4] = encode(8'h04) ^ 13'h0040;
    load_image();
    run_pass(14, 1, 4'd4, encode(8'h3C), dr, wrr);
    chk("collide writes", wr_count, 0);
    chk("collide mem4", mem[4], encode(8'h3C));
    chk("collide corr", corr_count, 8'd1);
    chk("collide done", dr, 49);

    // The host writes entry 7 for 3 cycles while entry 4 is in WRITE.
    do_reset();
    clean_image();
    img[4] = encode(8'h04) ^ 13'h0800;
    load_image();
    run_pass(15, 3, 4'd7, encode(8'h77), dr, wrr);
    chk("stall writes", wr_count, 1);
    chk("stall wr cycle", wrr, 18);
    chk("stall wr addr", wr_last_addr, 4'd4);
    chk("stall wr data", wr_last_data, encode(8'h04));
    chk("stall mem7", mem[7], encode(8'h77));
    chk("stall done", dr, 53);

    // Saturation: 20 passes with a single error in every entry.
    do_reset();
    for (int p = 0; p < 20; p++) begin
      for (int i = 0; i < DEPTH; i++) img[i] = encode(8'($urandom)) ^ (13'd1 << ($urandom % 13));
      load_image();
      run_pass(0, 0, 4'd0, 13'd0, dr, wrr);
    end
    chk("sat corr", corr_count, 8'd255);
    chk("sat uncorr", uncorr_count, 8'd0);

    // Reset asserted in the middle of a write-back.
    model_on = 1'b0;
    clean_image();
    bad = encode(8'h5A) ^ 13'h0020;
    img[0] = bad;
    load_image();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("pre-reset mem_wr_en", mem_wr_en, 1'b1);
    chk("pre-reset mem_addr", mem_addr, 4'd0);
    #2 rst = 1'b0;
    #1;
    chk("async mem_wr_en", mem_wr_en, 1'b0);
    chk("async busy", busy, 1'b0);
    chk("async done", done, 1'b0);
    chk("async mem_addr", mem_addr, 4'd0);
    chk("async mem_wdata", mem_wdata, 13'd0);
    chk("async corr", corr_count, 8'd0);
    chk("async uncorr", uncorr_count, 8'd0);
    chk("async flag", uncorr_flag, 1'b0);
    chk("async last", last_uncorr_addr, 4'd0);
    tick();
    tick();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle after reset", busy, 1'b0);
    end
    chk("aborted mem0", mem[0], bad);
    model_on = 1'b1;

    // Random traffic checked by the model.
    do_reset();
    for (int i = 0; i < DEPTH; i++) img[i] = rand_word();
    load_image();
    for (int c = 0; c < 4000; c++) begin
      start = ($urandom % 10) == 0;
      host_wr_en = ($urandom % 6) == 0;
      host_addr = 4'($urandom);
      host_wdata = rand_word();
      tick();
    end
    start = 1'b0;
    host_wr_en = 1'b0;
    for (int i = 0; i < 200 && busy; i++) tick();
    chk("quiesce busy", busy, 1'b0);
    tick();
    chk("final corr", corr_count, m_corr[7:0]);
    chk("final uncorr", uncorr_count, m_uncorr[7:0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
